// File: rtl/demux_sched_pkg.sv
// Shared constants and state encoding for the 1:4 stream scheduler.
// Imported by rr_pick_4 and demux_1_4_scheduler.
package demux_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } st_e;

endpackage

// File: rtl/rr_pick_4.sv
// Rotating first-ready finder: scans ptr, ptr+1, ... (mod 4).
// Ports: ready (4), ptr (2) -> idx (2), found; idx=ptr if none ready.
module rr_pick_4
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] ready,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   idx,
  output logic              found
);

  logic [CH_W-1:0] c;

  // Scan from the farthest offset down so the
  // nearest ready channel is the last one written.
  always_comb begin
    idx   = ptr;
    found = 1'b0;
    c     = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      c = ptr + CH_W'(i);
      if (ready[c]) begin
        idx   = c;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1_4_scheduler.sv
// Registered 1:4 valid/ready distributor, fixed or round-robin dest.
// Ports: Clock_In, Reset_N_In, Enable_In, Mode_In, Select_In,
//   Data_In/Valid_In/Ready_Out, Data_k/Valid_k_Out, Ready_k_In.
// Option DEMUX_SCHED_STATS_EN adds saturating Count_k_Out.
module demux_1_4_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                  Clock_In,
  input  logic                  Reset_N_In,
  input  logic                  Enable_In,
  input  logic                  Mode_In,
  input  logic [CH_W-1:0]       Select_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic                  Ready_Out,
  output logic [DATA_WIDTH-1:0] Data_0_Out,
  output logic [DATA_WIDTH-1:0] Data_1_Out,
  output logic [DATA_WIDTH-1:0] Data_2_Out,
  output logic [DATA_WIDTH-1:0] Data_3_Out,
  output logic                  Valid_0_Out,
  output logic                  Valid_1_Out,
  output logic                  Valid_2_Out,
  output logic                  Valid_3_Out,
`ifdef DEMUX_SCHED_STATS_EN
  output logic [COUNT_WIDTH-1:0] Count_0_Out,
  output logic [COUNT_WIDTH-1:0] Count_1_Out,
  output logic [COUNT_WIDTH-1:0] Count_2_Out,
  output logic [COUNT_WIDTH-1:0] Count_3_Out,
`endif
  input  logic                  Ready_0_In,
  input  logic                  Ready_1_In,
  input  logic                  Ready_2_In,
  input  logic                  Ready_3_In
);

  st_e                   st;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [CH_W-1:0]       buf_dest;
  logic [CH_W-1:0]       rr_ptr;

  logic                  buf_valid;
  logic [NUM_CH-1:0]     rdy;
  logic [NUM_CH-1:0]     vld;
  logic [DATA_WIDTH-1:0] dat [NUM_CH];
  logic                  drain;
  logic                  accept;
  logic [CH_W-1:0]       pick_idx;
  logic                  pick_found;
  logic [CH_W-1:0]       dest_sel;

  assign rdy = {Ready_3_In, Ready_2_In,
                Ready_1_In, Ready_0_In};

  assign buf_valid = (st == ST_FULL);

  assign drain = buf_valid & Enable_In
               & rdy[buf_dest];

  // Gated by reset so nothing is offered
  // while the block is held in reset.
  assign Ready_Out = Reset_N_In & Enable_In
                   & (~buf_valid | drain);

  assign accept = Valid_In & Ready_Out;

  rr_pick_4 u_pick (
    .ready (rdy),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign dest_sel = (Mode_In == MODE_RR)
                  ? pick_idx : Select_In;

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      st       <= ST_EMPTY;
      buf_data <= '0;
      buf_dest <= '0;
      rr_ptr   <= '0;
    end else begin
      unique case (st)
        ST_EMPTY: begin
          if (accept) begin
            st       <= ST_FULL;
            buf_data <= Data_In;
            buf_dest <= dest_sel;
            if (Mode_In == MODE_RR)
              rr_ptr <= dest_sel + 1'b1;
          end
        end
        ST_FULL: begin
          if (accept) begin
            buf_data <= Data_In;
            buf_dest <= dest_sel;
            if (Mode_In == MODE_RR)
              rr_ptr <= dest_sel + 1'b1;
          end else if (drain) begin
            st <= ST_EMPTY;
          end
        end
        default: st <= ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    vld = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      dat[k] = '0;
      if (buf_valid && buf_dest == CH_W'(k)) begin
        dat[k] = buf_data;
        vld[k] = Enable_In;
      end
    end
  end

  assign Valid_0_Out = vld[0];
  assign Valid_1_Out = vld[1];
  assign Valid_2_Out = vld[2];
  assign Valid_3_Out = vld[3];
  assign Data_0_Out  = dat[0];
  assign Data_1_Out  = dat[1];
  assign Data_2_Out  = dat[2];
  assign Data_3_Out  = dat[3];

`ifdef DEMUX_SCHED_STATS_EN
  logic [COUNT_WIDTH-1:0] cnt [NUM_CH];

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      for (int k = 0; k < NUM_CH; k++)
        cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (vld[k] && rdy[k] && cnt[k] != '1)
          cnt[k] <= cnt[k] + 1'b1;
    end
  end

  assign Count_0_Out = cnt[0];
  assign Count_1_Out = cnt[1];
  assign Count_2_Out = cnt[2];
  assign Count_3_Out = cnt[3];
`endif

endmodule

// File: tb/tb_demux_1_4_scheduler.sv
// Scoreboard bench for demux_1_4_scheduler: directed words in,
// monitor pops expected (channel, data) on each output transfer.
module tb_demux_1_4_scheduler;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [1:0] sel;
  logic [7:0] din;
  logic       vin;
  logic       ready_out;
  logic [7:0] d0, d1, d2, d3;
  logic       v0, v1, v2, v3;
  logic [3:0] rdy;
  logic [3:0] vld;
  logic [7:0] dout [4];
`ifdef DEMUX_SCHED_STATS_EN
  logic [3:0] c0, c1, c2, c3;
`endif

  exp_t sb_q[$];
  int   pass_cnt;
  int   tot_cnt;
  int   cyc;
  int   t0;

  demux_1_4_scheduler #(
    .DATA_WIDTH  (8),
    .COUNT_WIDTH (4)
  ) dut (
    .Clock_In    (clk),
    .Reset_N_In  (rst_n),
    .Enable_In   (en),
    .Mode_In     (mode),
    .Select_In   (sel),
    .Data_In     (din),
    .Valid_In    (vin),
    .Ready_Out   (ready_out),
    .Data_0_Out  (d0),
    .Data_1_Out  (d1),
    .Data_2_Out  (d2),
    .Data_3_Out  (d3),
    .Valid_0_Out (v0),
    .Valid_1_Out (v1),
    .Valid_2_Out (v2),
    .Valid_3_Out (v3),
`ifdef DEMUX_SCHED_STATS_EN
    .Count_0_Out (c0),
    .Count_1_Out (c1),
    .Count_2_Out (c2),
    .Count_3_Out (c3),
`endif
    .Ready_0_In  (rdy[0]),
    .Ready_1_In  (rdy[1]),
    .Ready_2_In  (rdy[2]),
    .Ready_3_In  (rdy[3])
  );

  assign vld = {v3, v2, v1, v0};

  always_comb begin
    dout[0] = d0;
    dout[1] = d1;
    dout[2] = d2;
    dout[3] = d3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Monitor: one transfer per valid&ready, checked
  // against the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("onehot", 32'($countones(vld) <= 1), 1);
        for (int k = 0; k < 4; k++) begin
          if (en && !vld[k])
            chk("idle_data_zero", 32'(dout[k]), 0);
          if (vld[k] && rdy[k]) begin
            if (sb_q.size() == 0) begin
              chk("spurious_xfer", 32'(k), 32'hFF);
            end else begin
              e = sb_q.pop_front();
              chk("xfer_ch", 32'(k), 32'(e.ch));
              chk("xfer_data", 32'(dout[k]), 32'(e.d));
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d,
                      input logic m,
                      input logic [1:0] s,
                      input logic [1:0] ch);
    int n;
    exp_t e;
    e.ch = ch;
    e.d  = d;
    sb_q.push_back(e);
    din  = d;
    mode = m;
    sel  = s;
    vin  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_out && n < 20);
    chk("send_accept", 32'(ready_out), 1);
    @(posedge clk);
    #1;
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    cyc   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    sel   = 2'd0;
    din   = 8'h00;
    vin   = 1'b0;
    rdy   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_out), 0);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_data", 32'(d0 | d1 | d2 | d3), 0);
    rst_n = 1'b1;
    idle(1);

    // fixed select
    send(8'hA5, 1'b0, 2'd2, 2'd2);
    chk("fix_valid", 32'(vld), 32'h4);
    chk("fix_data2", 32'(d2), 32'hA5);
    chk("fix_others", 32'(d0 | d1 | d3), 0);
    idle(1);
    chk("empty_valid", 32'(vld), 0);
    chk("empty_ready", 32'(ready_out), 1);

    // round-robin, all ready, back-to-back
    t0 = cyc;
    send(8'd1, 1'b1, 2'd0, 2'd0);
    send(8'd2, 1'b1, 2'd0, 2'd1);
    send(8'd3, 1'b1, 2'd0, 2'd2);
    send(8'd4, 1'b1, 2'd0, 2'd3);
    send(8'd5, 1'b1, 2'd0, 2'd0);
    chk("rr_rate", 32'(cyc - t0), 5);
    idle(1);

    // ptr=1, ch1 busy -> ch2
    rdy = 4'b1101;
    send(8'h33, 1'b1, 2'd0, 2'd2);
    idle(1);
    rdy = 4'hF;
    send(8'h34, 1'b1, 2'd0, 2'd3);
    send(8'h35, 1'b1, 2'd0, 2'd0);
    idle(1);
    // none ready -> ptr channel, held
    rdy = 4'h0;
    send(8'h44, 1'b1, 2'd0, 2'd1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", 32'(ready_out), 0);
      chk("hold_valid", 32'(vld), 32'h2);
      chk("hold_data", 32'(d1), 32'h44);
    end
    @(posedge clk);
    #1;
    rdy[1] = 1'b1;
    idle(1);
    rdy = 4'hF;

    // stalled on ch3, mode/select wiggle
    rdy = 4'b0111;
    send(8'h55, 1'b0, 2'd3, 2'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
      mode = ~mode;
      sel  = sel + 2'd1;
      @(negedge clk);
      chk("stall_valid", 32'(vld), 32'h8);
      chk("stall_data", 32'(d3), 32'h55);
      chk("stall_ready", 32'(ready_out), 0);
    end
    @(posedge clk);
    #1;
    rdy = 4'hF;
    idle(1);
    send(8'h66, 1'b1, 2'd0, 2'd2);
    idle(1);

    // enable low while full
    rdy = 4'b1110;
    send(8'h77, 1'b0, 2'd0, 2'd0);
    en  = 1'b0;
    rdy = 4'hF;
    repeat (2) begin
      @(negedge clk);
      chk("dis_valid", 32'(vld), 0);
      chk("dis_ready", 32'(ready_out), 0);
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    @(negedge clk);
    chk("reen_valid", 32'(vld), 32'h1);
    chk("reen_data", 32'(d0), 32'h77);
    idle(1);

    // reset mid-stream drops the word
    rdy = 4'b1101;
    send(8'h88, 1'b0, 2'd1, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(vld), 0);
    chk("mid_rst_ready", 32'(ready_out), 0);
    chk("mid_rst_data", 32'(d0 | d1 | d2 | d3), 0);
    void'(sb_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy = 4'hF;
    send(8'h99, 1'b1, 2'd0, 2'd0);
    idle(1);

`ifdef DEMUX_SCHED_STATS_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 20; i++)
      send(8'(i), 1'b0, 2'd0, 2'd0);
    idle(1);
    chk("cnt0_sat", 32'(c0), 15);
    chk("cnt_others", 32'(c1 | c2 | c3), 0);
`endif

    @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/demux_1_4_scheduler.md
Name: demux_1_4_scheduler

Overview:
- Registered 1:4 stream distributor. It accepts words on one valid/ready input and routes each word to exactly one of four valid/ready output channels.
- The destination is either a fixed Select_In value or a round-robin choice that prefers ready channels.
- It sits in front of four parallel consumers and replaces a bare combinational 1:4 demux wherever back-pressure and fair sharing are needed.

Parameters:
- DATA_WIDTH, 8, width of the data word.
- COUNT_WIDTH, 16, width of each statistics counter (used only with the optional feature).

Ports:
- Clock_In  input  1  system clock; all state updates on the rising edge.
- Reset_N_In  input  1  asynchronous active-low reset.
- Enable_In  input  1  block enable; low freezes the block.
- Mode_In  input  1  0 = fixed select, 1 = round-robin.
- Select_In  input  2  destination channel in fixed mode.
- Data_In  input  DATA_WIDTH  input word.
- Valid_In  input  1  input word valid.
- Ready_Out  output  1  block can accept a word this cycle.
- Data_k_Out (k=0..3)  output  DATA_WIDTH  channel k data.
- Valid_k_Out (k=0..3)  output  1  channel k valid.
- Ready_k_In (k=0..3)  input  1  channel k consumer ready.
- Count_k_Out (k=0..3)  output  COUNT_WIDTH  channel k transfer count (optional feature only).

Behaviour:
- Storage: one holding register containing Buf_Data, Buf_Dest (2 bits) and Buf_Valid. Round-robin pointer Rr_Ptr is 2 bits.
- States:
  - EMPTY (Buf_Valid=0).
  - FULL (Buf_Valid=1).
- Reset: Buf_Valid=0, Buf_Data=0, Buf_Dest=0, Rr_Ptr=0, all counters 0. Every Valid_k_Out, Data_k_Out and Ready_Out is 0 while Reset_N_In is low. Reset mid-transfer discards the buffered word.
- Drain: Drain = Buf_Valid & Enable_In & Ready_(Buf_Dest)_In.
- Accept:
  - Ready_Out = Enable_In & (~Buf_Valid | Drain). This is combinational from Ready_k_In.
  - Accept = Valid_In & Ready_Out.
- Outputs:
  - Valid_k_Out = Enable_In & Buf_Valid & (Buf_Dest==k).
  - Data_k_Out = Buf_Data when Buf_Dest==k and Buf_Valid, else 0. Non-selected channels drive 0.
- Destination choice at Accept:
  - Fixed mode: Select_In.
  - Round-robin: scan channels Rr_Ptr, Rr_Ptr+1, ... (mod 4) and take the first with Ready_k_In=1. If none is ready, take Rr_Ptr.
  - In round-robin mode, Rr_Ptr <= chosen+1 mod 4 on Accept (wraps 3 -> 0). In fixed mode Rr_Ptr is unchanged.
- Transitions:
  - EMPTY + Accept -> FULL (load word and destination).
  - FULL + Drain + Accept -> FULL (new word loaded in the same cycle; full throughput).
  - FULL + Drain + ~Accept -> EMPTY.
  - FULL + ~Drain -> FULL; the word is held stable, with data and destination unchanged.
- Latency: the word is visible on its channel 1 cycle after Accept. Sustained rate is 1 word/cycle when the destinations are ready.
- Enable_In low:
  - Ready_Out=0, all Valid_k_Out=0.
  - Buffer, Rr_Ptr and counters hold.
  - On re-enable, the held word is presented to its original destination.
- Mode_In and Select_In are sampled only at Accept. Changing them while FULL does not redirect the buffered word.
- Valid_In low with the buffer draining: go to EMPTY, pointer unchanged.

Optional Feature:
- Macro DEMUX_SCHED_STATS_EN.
- Defined:
  - Count_k_Out ports exist.
  - Each counter increments by 1 on each cycle where Valid_k_Out & Ready_k_In.
  - Counters saturate at 2^COUNT_WIDTH-1 (no wrap). Reset clears them to 0.
  - Counters hold while Enable_In is low.
- Undefined: the Count_k_Out ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package demux_sched_pkg:
  - NUM_CH=4.
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - State encoding ST_EMPTY/ST_FULL.
  - Channel index width CH_W=2.
- Sub-module rr_pick_4: combinational rotating first-ready finder (inputs: 4-bit ready vector, 2-bit pointer; outputs: 2-bit index, found flag).
- Top level: buffer register, state, pointer, output decode, optional counters.

Test Plan:
- Reset then fixed mode, Select_In=2, Data_In=8'hA5, Valid_In=1 for one cycle, all ready -> next cycle Valid_2_Out=1, Data_2_Out=A5; other Valid/Data outputs 0; then EMPTY.
- Round-robin, all ready, words 1,2,3,4,5 back-to-back -> delivered on channels 0,1,2,3,0. Ready_Out stays 1 throughout; one word per cycle.
- Round-robin, Rr_Ptr=1, Ready_1_In=0, Ready_2_In=1 -> word goes to channel 2, Rr_Ptr becomes 3. With all Ready_k_In=0 -> word goes to channel 1 and is held; Ready_Out=0 until Ready_1_In rises.
- FULL with destination 3 not ready, 3 cycles; toggle Select_In and Mode_In -> Data_3_Out stable, no other Valid asserts. Ready_3_In=1 -> drained; the next word follows the new mode.
- Enable_In low while FULL -> all Valid 0, Ready_Out 0. Re-enable -> same word appears on the same channel. Assert Reset_N_In low mid-stream -> all outputs 0 immediately; word lost.
- With DEMUX_SCHED_STATS_EN and COUNT_WIDTH=4: 20 transfers to channel 0 -> Count_0_Out=15 (saturated), others 0.
